// File: rtl/centering_buffer.sv
// centering_buffer
//   Centering stage in front of the 4x4 whitening multiplier. A frame of
//   N = 2**LOG2_N four-channel samples is captured into a block RAM while
//   per-channel sums are accumulated. The per-channel mean is then formed,
//   and the frame is replayed with the mean subtracted and the result
//   saturated to W bits. out_en drives the multiplier's En directly.
//
//   Optional macro: CENTER_ROUND_EN
//     defined     -> mean = (acc + N/2) >>> LOG2_N  (round half up, LOG2_N >= 1)
//     not defined -> mean = acc >>> LOG2_N          (floor)
//
//   Pipeline timing, counted from the edge that takes the last sample:
//     +1 MEAN   : means latched, accumulators cleared
//     +2 STREAM : first RAM read registered
//     +3        : first centred sample registered, out_en high
//   DRAIN covers the two-cycle pipeline tail and ends with a one-cycle done.
module centering_buffer #(
    parameter int W      = 26,
    parameter int LOG2_N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] X1_in,
    input  logic signed [W-1:0] X2_in,
    input  logic signed [W-1:0] X3_in,
    input  logic signed [W-1:0] X4_in,
    output logic                out_en,
    output logic signed [W-1:0] X1,
    output logic signed [W-1:0] X2,
    output logic signed [W-1:0] X3,
    output logic signed [W-1:0] X4,
    output logic                done
);

    localparam int N  = 2 ** LOG2_N;
    // Accumulator holds the sum of N W-bit samples exactly.
    localparam int AW = W + LOG2_N;
    // End of a load or stream phase is the last pointer value, not the wrap.
    localparam logic [LOG2_N-1:0] PTR_LAST = {LOG2_N{1'b1}};
    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`ifdef CENTER_ROUND_EN
    localparam logic signed [AW-1:0] ROUND_BIAS = AW'(N / 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MEAN,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t            state_q;
    logic [LOG2_N-1:0] wr_ptr_q;
    logic [LOG2_N-1:0] rd_ptr_q;
    logic              in_ready_q;
    logic              rd_vld_q;   // rd_data_q holds a frame sample this cycle
    logic              out_en_q;
    logic              done_q;
    logic              drain_q;    // second DRAIN cycle marker

    logic              accept;
    logic [4*W-1:0]    wr_data;
    logic [4*W-1:0]    rd_data_q;
    logic [4*W-1:0]    mem_q [N];

    // Channel k occupies bits [k*W +: W] of a RAM word, X1 in the low slice.
    assign wr_data = {X4_in, X3_in, X2_in, X1_in};
    assign accept  = in_valid && in_ready_q && (state_q == S_LOAD);

    // Frame sequencing: phase control, pointers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            out_en_q   <= 1'b0;
            done_q     <= 1'b0;
            drain_q    <= 1'b0;
        end else begin
            // out_en follows the RAM read by one cycle, matching the
            // subtract register, so it is always aligned with X1..X4.
            out_en_q <= rd_vld_q;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        wr_ptr_q   <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        wr_ptr_q <= wr_ptr_q + LOG2_N'(1);
                        if (wr_ptr_q == PTR_LAST) begin
                            // Drop ready together with the phase change so
                            // no sample past the N-th can be taken.
                            in_ready_q <= 1'b0;
                            state_q    <= S_MEAN;
                        end
                    end
                end
                S_MEAN: begin
                    rd_ptr_q <= '0;
                    state_q  <= S_STREAM;
                end
                S_STREAM: begin
                    rd_vld_q <= 1'b1;
                    rd_ptr_q <= rd_ptr_q + LOG2_N'(1);
                    if (rd_ptr_q == PTR_LAST) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    rd_vld_q <= 1'b0;
                    drain_q  <= ~drain_q;
                    if (drain_q) begin
                        // out_en is falling on this same edge.
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Frame buffer: write on accept, registered read during STREAM. Contents
    // are never cleared; every word read was written in the same frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
        if (state_q == S_STREAM) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic signed [AW-1:0] acc_q;
            logic signed [W-1:0]  mean_q;
            logic signed [W-1:0]  x_q;
            logic signed [AW-1:0] acc_bias;
            logic signed [W-1:0]  mean_d;
            logic signed [W-1:0]  buf_val;
            logic signed [W:0]    diff;
            logic signed [W-1:0]  sat_d;

            // Mean of the accumulated frame; the shifted value always fits W bits.
            always_comb begin
`ifdef CENTER_ROUND_EN
                acc_bias = acc_q + ROUND_BIAS;
`else
                acc_bias = acc_q;
`endif
                mean_d = W'(acc_bias >>> LOG2_N);
            end

            // Centre one buffered sample: widen by one bit, subtract, clamp.
            always_comb begin
                buf_val = rd_data_q[gi*W +: W];
                diff    = (W+1)'(buf_val) - (W+1)'(mean_q);
                if (diff[W] != diff[W-1]) begin
                    sat_d = diff[W] ? SAT_MIN : SAT_MAX;
                end else begin
                    sat_d = diff[W-1:0];
                end
            end

            // Per-channel sum during LOAD; MEAN latches the mean and clears
            // the sum so the next frame starts from zero.
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q  <= '0;
                    mean_q <= '0;
                end else if (state_q == S_MEAN) begin
                    mean_q <= mean_d;
                    acc_q  <= '0;
                end else if (accept) begin
                    acc_q <= acc_q + AW'($signed(wr_data[gi*W +: W]));
                end
            end

            // Registered centred output, held at zero whenever out_en is low.
            always_ff @(posedge clk) begin
                if (rst) begin
                    x_q <= '0;
                end else begin
                    x_q <= rd_vld_q ? sat_d : '0;
                end
            end
        end
    endgenerate

    assign in_ready = in_ready_q;
    assign out_en   = out_en_q;
    assign done     = done_q;
    assign X1       = g_ch[0].x_q;
    assign X2       = g_ch[1].x_q;
    assign X3       = g_ch[2].x_q;
    assign X4       = g_ch[3].x_q;

endmodule

// File: tb/tb_centering_buffer.sv
// Testbench for centering_buffer. Main instance uses LOG2_N=2 (N=4); a second
// instance with LOG2_N=1 covers the two-sample saturation case. Table frames,
// a gapped-valid frame, a reset-mid-stream frame and random frames are each
// compared against expected values built by the bench.
`timescale 1ns/1ps
module tb_centering_buffer;

    localparam int W  = 26;
    localparam int LG = 2;
    localparam int N  = 1 << LG;

    typedef logic [3:0][3:0][W-1:0] frame_t;   // [sample][channel]
    typedef struct packed {
        frame_t x;
        frame_t e;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] X1_in, X2_in, X3_in, X4_in;
    logic                out_en;
    logic signed [W-1:0] X1, X2, X3, X4;
    logic                done;

    logic                s1_start;
    logic                s1_in_valid;
    logic                s1_in_ready;
    logic signed [W-1:0] s1_x1_in, s1_x2_in, s1_x3_in, s1_x4_in;
    logic                s1_out_en;
    logic signed [W-1:0] s1_x1, s1_x2, s1_x3, s1_x4;
    logic                s1_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    centering_buffer #(.W(W), .LOG2_N(LG)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .X1_in(X1_in), .X2_in(X2_in), .X3_in(X3_in), .X4_in(X4_in),
        .out_en(out_en), .X1(X1), .X2(X2), .X3(X3), .X4(X4), .done(done)
    );

    centering_buffer #(.W(W), .LOG2_N(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .X1_in(s1_x1_in), .X2_in(s1_x2_in), .X3_in(s1_x3_in), .X4_in(s1_x4_in),
        .out_en(s1_out_en), .X1(s1_x1), .X2(s1_x2), .X3(s1_x3), .X4(s1_x4), .done(s1_done)
    );

    task automatic chk(input string name, input logic signed [63:0] act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [W-1:0] xo(input int c);
        case (c)
            0:       return X1;
            1:       return X2;
            2:       return X3;
            default: return X4;
        endcase
    endfunction

    function automatic frame_t set_ch(input frame_t f, input int c,
                                      input int v0, input int v1, input int v2, input int v3);
        frame_t r;
        r = f;
        r[0][c] = W'(v0);
        r[1][c] = W'(v1);
        r[2][c] = W'(v2);
        r[3][c] = W'(v3);
        return r;
    endfunction

    // Reference: mean = floor(sum / n) (or floor((sum + n/2) / n) when
    // rounding), then each sample minus the mean clamped to the W-bit range.
    function automatic frame_t model(input frame_t s, input int lg);
        frame_t r;
        int     n;
        longint sum, m, d;
        longint lo, hi;
        r  = '0;
        n  = 1 << lg;
        hi = (64'sd1 <<< (W-1)) - 1;
        lo = -(64'sd1 <<< (W-1));
        for (int c = 0; c < 4; c++) begin
            sum = 0;
            for (int k = 0; k < n; k++) sum += longint'($signed(s[k][c]));
`ifdef CENTER_ROUND_EN
            sum += n / 2;
`endif
            m = sum / n;
            if ((sum % n != 0) && (sum < 0)) m--;
            for (int k = 0; k < n; k++) begin
                d = longint'($signed(s[k][c])) - m;
                if (d > hi) d = hi;
                if (d < lo) d = lo;
                r[k][c] = W'(d);
            end
        end
        return r;
    endfunction

    task automatic drive(input logic [3:0][W-1:0] s);
        X1_in = s[0];
        X2_in = s[1];
        X3_in = s[2];
        X4_in = s[3];
    endtask

    task automatic drive_junk();
        X1_in = W'($urandom);
        X2_in = W'($urandom);
        X3_in = W'($urandom);
        X4_in = W'($urandom);
    endtask

    // mode 0: in_valid held high; 1: pattern 1,0,0,1,1,0,1 with an extra start
    // mid-load; 2: random valid and random starts. rst_at >= 0 asserts reset
    // during that out_en cycle and abandons the frame.
    // Entered and left on a negedge; start is raised in the entry cycle.
    task automatic run_frame(input string name, input frame_t smp, input frame_t exp,
                             input int mode, input int rst_at);
        int acc_cnt;
        int pi;
        int k;
        bit v;
        bit will_acc;
        bit seen_done;
        bit pat[7];
        pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        acc_cnt  = 0;
        pi       = 0;
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_ready_up"}, in_ready, 1);
        while (acc_cnt < N) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = pat[pi % 7];
            else                v = 1'($urandom_range(0, 1));
            start    = ((mode == 1) && (pi == 2)) || ((mode == 2) && ($urandom_range(0, 5) == 0));
            in_valid = v;
            if (v) drive(smp[acc_cnt]);
            else   drive_junk();
            will_acc = v && in_ready;
            pi++;
            @(negedge clk);
            if (will_acc) acc_cnt++;
            if (pi > 200) begin
                chk({name, "_load_timeout"}, acc_cnt, N);
                start    = 1'b0;
                in_valid = 1'b0;
                return;
            end
        end
        // Junk keeps arriving in the gapped modes; none of it may be taken.
        start    = 1'b0;
        in_valid = (mode != 0);
        drive_junk();
        chk({name, "_ready_drop"}, in_ready, 0);
        k = 0;
        while (!out_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_latency"}, k, 3);
        for (int s = 0; s < N; s++) begin
            chk($sformatf("%s_s%0d_en", name, s), out_en, 1);
            for (int c = 0; c < 4; c++)
                chk($sformatf("%s_s%0d_X%0d", name, s, c + 1), xo(c),
                    longint'($signed(exp[s][c])));
            if (s == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst      = 1'b0;
                in_valid = 1'b0;
                chk({name, "_rst_en"}, out_en, 0);
                for (int c = 0; c < 4; c++)
                    chk($sformatf("%s_rst_X%0d", name, c + 1), xo(c), 0);
                seen_done = done;
                repeat (8) begin
                    @(negedge clk);
                    if (done) seen_done = 1'b1;
                end
                chk({name, "_rst_no_done"}, seen_done, 0);
                $display("frame %s: reset during stream sample %0d", name, s);
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({name, "_tail_en"}, out_en, 0);
        chk({name, "_done"}, done, 1);
        for (int c = 0; c < 4; c++)
            chk($sformatf("%s_tail_X%0d", name, c + 1), xo(c), 0);
        @(negedge clk);
        chk({name, "_done_pulse"}, done, 0);
        $display("frame %s: %0d samples streamed", name, N);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   tbl[4];
        frame_t s;
        int     k;

        // Table: 0 = single-channel ramp, 1 = mean rounding of -1/4,
        // 2 = saturation and rounding across all channels, 3 = repeat of 0.
        tbl[0].x = set_ch('0, 0, 10, 20, 30, 40);
        tbl[0].e = set_ch('0, 0, -15, -5, 5, 15);
        tbl[1].x = set_ch('0, 0, -1, 0, 0, 0);
`ifdef CENTER_ROUND_EN
        tbl[1].e = set_ch('0, 0, -1, 0, 0, 0);
`else
        tbl[1].e = set_ch('0, 0, 0, 1, 1, 1);
`endif
        tbl[2].x = set_ch('0,       0, 33554431, 33554431, -33554432, -33554432);
        tbl[2].x = set_ch(tbl[2].x, 1, -33554432, -33554432, -33554432, -33554432);
        tbl[2].x = set_ch(tbl[2].x, 2, 100, -100, 7, -8);
        tbl[2].x = set_ch(tbl[2].x, 3, 5, 6, 7, 8);
`ifdef CENTER_ROUND_EN
        tbl[2].e = set_ch('0,       0, 33554431, 33554431, -33554432, -33554432);
        tbl[2].e = set_ch(tbl[2].e, 2, 100, -100, 7, -8);
        tbl[2].e = set_ch(tbl[2].e, 3, -2, -1, 0, 1);
`else
        tbl[2].e = set_ch('0,       0, 33554431, 33554431, -33554431, -33554431);
        tbl[2].e = set_ch(tbl[2].e, 2, 101, -99, 8, -7);
        tbl[2].e = set_ch(tbl[2].e, 3, -1, 0, 1, 2);
`endif
        tbl[3] = tbl[0];

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        X1_in = '0; X2_in = '0; X3_in = '0; X4_in = '0;
        s1_start = 1'b0; s1_in_valid = 1'b0;
        s1_x1_in = '0; s1_x2_in = '0; s1_x3_in = '0; s1_x4_in = '0;
        repeat (3) @(negedge clk);
        // start together with reset: reset wins
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk("reset_ready", in_ready, 0);
        chk("reset_en", out_en, 0);
        chk("reset_done", done, 0);
        for (int c = 0; c < 4; c++) chk($sformatf("reset_X%0d", c + 1), xo(c), 0);
        // in_valid in IDLE is ignored and must not disturb the next frame
        in_valid = 1'b1;
        X1_in    = 12345;
        repeat (3) @(negedge clk);
        chk("idle_ready", in_ready, 0);
        in_valid = 1'b0;

        // back-to-back table frames
        for (int i = 0; i < 4; i++)
            run_frame($sformatf("tbl%0d", i), tbl[i].x, tbl[i].e, 0, -1);

        // gapped valid with a repeated start
        run_frame("gapped", tbl[0].x, tbl[0].e, 1, -1);

        // reset on the second out_en cycle, then a clean frame
        run_frame("rst_mid", tbl[0].x, tbl[0].e, 0, 1);
        run_frame("after_rst", tbl[0].x, tbl[0].e, 0, -1);

        // randomized frames against the reference model
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < N; a++)
                for (int c = 0; c < 4; c++)
                    s[a][c] = (r % 2 == 1) ? W'($urandom)
                                           : W'($urandom_range(0, 2000)) - W'(1000);
            run_frame($sformatf("rand%0d", r), s, model(s, LG), 2, -1);
        end

        // LOG2_N=1 instance: full-scale pair with saturation
        s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        chk("n2_ready_up", s1_in_ready, 1);
        s1_in_valid = 1'b1;
        s1_x1_in    = 33554431;
        @(negedge clk);
        s1_x1_in = -33554432;
        @(negedge clk);
        s1_in_valid = 1'b0;
        s1_x1_in    = '0;
        k = 0;
        while (!s1_out_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("n2_latency", k, 3);
        chk("n2_s0_X1", s1_x1, 33554431);
        chk("n2_s0_X2", s1_x2, 0);
        chk("n2_s0_X3", s1_x3, 0);
        chk("n2_s0_X4", s1_x4, 0);
        @(negedge clk);
        chk("n2_s1_en", s1_out_en, 1);
`ifdef CENTER_ROUND_EN
        chk("n2_s1_X1", s1_x1, -33554432);
`else
        chk("n2_s1_X1", s1_x1, -33554431);
`endif
        @(negedge clk);
        chk("n2_tail_en", s1_out_en, 0);
        chk("n2_done", s1_done, 1);
        $display("frame n2: 2 samples streamed");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
